// File: rtl/clock_divider_ff.sv
// Integer clock divider: produces a near-50% duty divided clock and a
// one-cycle strobe on each of its rising edges. DIV == 1 passes clk through.
`timescale 1ns/1ps
module clock_divider_ff #(
  parameter int unsigned CLK_FREQ    = 50000000,
  parameter int unsigned SAMPLE_RATE = 48000
) (
  input  logic clk,
  input  logic rst_n,
  output logic out,
  output logic tick
);

  localparam int unsigned DIV_RAW = CLK_FREQ / SAMPLE_RATE;
  localparam int unsigned DIV     = (DIV_RAW == 0) ? 1 : DIV_RAW;
  localparam int unsigned CW      = (DIV <= 2) ? 1 : $clog2(DIV);
  localparam int unsigned HI      = DIV - (DIV / 2);

  generate
    if (DIV == 1) begin : g_bypass
      // No slower clock exists; the input clock is gated by reset.
      assign out  = clk & rst_n;
      assign tick = rst_n;
    end else begin : g_div
      localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
      localparam logic [CW-1:0] CNT_HI  = CW'(HI);

      logic [CW-1:0] cnt;
      logic [CW-1:0] cnt_next;
      logic          out_q;
      logic          tick_q;

      always_comb begin
        cnt_next = '0;
        if (cnt != CNT_MAX) begin
          cnt_next = cnt + CW'(1);
        end
      end

      // Reset parks the counter at its last value so the first edge wraps to 0.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt    <= CNT_MAX;
          out_q  <= 1'b0;
          tick_q <= 1'b0;
        end else begin
          cnt    <= cnt_next;
          out_q  <= (cnt_next < CNT_HI);
          tick_q <= (cnt_next == '0);
        end
      end

      assign out  = out_q;
      assign tick = tick_q;
    end
  endgenerate

endmodule

// File: tb/tb_clock_divider_ff.sv
// Directed bench for clock_divider_ff across several divisor configurations.
`timescale 1ns/1ps
module tb_clock_divider_ff;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic out4, tick4, out5, tick5, out3, tick3;
  logic out1a, tick1a, out1b, tick1b, outd, tickd;
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  clock_divider_ff #(.CLK_FREQ(100), .SAMPLE_RATE(25)) u_div4 (
    .clk(clk), .rst_n(rst_n), .out(out4), .tick(tick4));
  clock_divider_ff #(.CLK_FREQ(100), .SAMPLE_RATE(20)) u_div5 (
    .clk(clk), .rst_n(rst_n), .out(out5), .tick(tick5));
  clock_divider_ff #(.CLK_FREQ(100), .SAMPLE_RATE(30)) u_div3 (
    .clk(clk), .rst_n(rst_n), .out(out3), .tick(tick3));
  clock_divider_ff #(.CLK_FREQ(48000), .SAMPLE_RATE(48000)) u_div1a (
    .clk(clk), .rst_n(rst_n), .out(out1a), .tick(tick1a));
  clock_divider_ff #(.CLK_FREQ(10), .SAMPLE_RATE(20)) u_div1b (
    .clk(clk), .rst_n(rst_n), .out(out1b), .tick(tick1b));
  clock_divider_ff u_divd (
    .clk(clk), .rst_n(rst_n), .out(outd), .tick(tickd));

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] got;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    got = {out4, tick4, out5, tick5, out3, tick3, out1a, out1b};
    total++;
    if (got !== 8'h00) $display("FAIL reset_outputs got=%b exp=%b", got, 8'h00);
    else passed++;
    @(posedge clk);
    #1;
    got = {out4, tick4, out5, tick5, out3, tick3, out1a, out1b};
    total++;
    if (got !== 8'h00) $display("FAIL reset_held_clk_high got=%b exp=%b", got, 8'h00);
    else passed++;
    total++;
    if ({tick1a, tick1b, outd, tickd} !== 4'b0000)
      $display("FAIL reset_tick_div1 got=%b exp=0000", {tick1a, tick1b, outd, tickd});
    else passed++;
  endtask

  task automatic test_patterns();
    logic [1:0] exp4, exp5, exp3;
    do_reset();
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      exp4 = {((i % 4) < 2), ((i % 4) == 0)};
      exp5 = {((i % 5) < 3), ((i % 5) == 0)};
      exp3 = {((i % 3) < 2), ((i % 3) == 0)};
      total++;
      if ({out4, tick4} !== exp4)
        $display("FAIL div4_cycle%0d got out/tick=%b exp=%b", i, {out4, tick4}, exp4);
      else passed++;
      total++;
      if ({out5, tick5} !== exp5)
        $display("FAIL div5_cycle%0d got out/tick=%b exp=%b", i, {out5, tick5}, exp5);
      else passed++;
      total++;
      if ({out3, tick3} !== exp3)
        $display("FAIL div3_cycle%0d got out/tick=%b exp=%b", i, {out3, tick3}, exp3);
      else passed++;
    end
  endtask

  task automatic test_div1();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      total++;
      if ({out1a, out1b, tick1a, tick1b} !== 4'b1111)
        $display("FAIL div1_clk_high got=%b exp=1111", {out1a, out1b, tick1a, tick1b});
      else passed++;
      @(negedge clk);
      #1;
      total++;
      if ({out1a, out1b, tick1a, tick1b} !== 4'b0011)
        $display("FAIL div1_clk_low got=%b exp=0011", {out1a, out1b, tick1a, tick1b});
      else passed++;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if ({out1a, out1b, tick1a, tick1b} !== 4'b0000)
      $display("FAIL div1_in_reset got=%b exp=0000", {out1a, out1b, tick1a, tick1b});
    else passed++;
  endtask

  task automatic test_async_reset();
    logic [1:0] exp4;
    do_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    total++;
    if ({out4, tick4} !== 2'b10)
      $display("FAIL pulse_pre got out/tick=%b exp=10", {out4, tick4});
    else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({out4, tick4} !== 2'b00)
      $display("FAIL pulse_async_drop got out/tick=%b exp=00", {out4, tick4});
    else passed++;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      exp4 = {((i % 4) < 2), ((i % 4) == 0)};
      total++;
      if ({out4, tick4} !== exp4)
        $display("FAIL pulse_resume_cycle%0d got out/tick=%b exp=%b", i, {out4, tick4}, exp4);
      else passed++;
    end
  endtask

  task automatic test_default_period();
    int   rises = 0;
    int   last_rise = -1;
    int   last_fall = -1;
    logic prev = 1'b0;
    do_reset();
    for (int i = 0; i < 11 * 1041 + 20; i++) begin
      @(posedge clk);
      #1;
      if (outd && !prev) begin
        total++;
        if (tickd !== 1'b1) $display("FAIL dflt_tick_at_rise got=%b exp=1", tickd);
        else passed++;
        if (last_rise >= 0) begin
          total++;
          if (i - last_rise != 1041)
            $display("FAIL dflt_period got=%0d exp=1041", i - last_rise);
          else passed++;
          total++;
          if (i - last_fall != 520)
            $display("FAIL dflt_low_phase got=%0d exp=520", i - last_fall);
          else passed++;
        end
        last_rise = i;
        rises++;
      end
      if (!outd && prev) begin
        total++;
        if (i - last_rise != 521)
          $display("FAIL dflt_high_phase got=%0d exp=521", i - last_rise);
        else passed++;
        last_fall = i;
      end
      prev = outd;
      if (rises == 11) break;
    end
    total++;
    if (rises != 11) $display("FAIL dflt_rise_count got=%0d exp=11", rises);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_div1();
    test_async_reset();
    test_default_period();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/clock_divider_ff.md
CLOCK_DIVIDER_FF -- requirements
Module: clock_divider_ff

Interface
REQ-001 Parameter CLK_FREQ, default 50000000: input clock frequency in Hz, positive integer.
REQ-002 Parameter SAMPLE_RATE, default 48000: target output frequency in Hz, positive integer.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port out, output, 1 bit: divided clock, nominal frequency SAMPLE_RATE.
REQ-006 Port tick, output, 1 bit: one-clk-cycle strobe marking each rising edge of out.

Function
REQ-007 Divisor DIV SHALL be computed at elaboration as floor(CLK_FREQ / SAMPLE_RATE).
- If the result is 0 (SAMPLE_RATE > CLK_FREQ), DIV SHALL be clamped to 1.
REQ-008 Counter cnt SHALL be max(1, ceil(log2(DIV))) bits wide and SHALL count 0..DIV-1.
REQ-009 HI = DIV - floor(DIV/2) (ceiling half); LO = floor(DIV/2).
REQ-010 For DIV >= 2, on each clk rising edge with rst_n high:
- cnt_next = 0 if cnt == DIV-1, else cnt+1; cnt <= cnt_next.
REQ-011 For DIV >= 2, out SHALL be a register: out <= (cnt_next < HI).
- Result: out is high for HI clk cycles and low for LO clk cycles; period is exactly DIV clk cycles.
REQ-012 For odd DIV, the high phase SHALL be one cycle longer than the low phase; no negative-edge logic is used.
REQ-013 For DIV >= 2, tick SHALL be a register: tick <= (cnt_next == 0).
- tick is high during exactly the first clk cycle of each out-high phase.
REQ-014 For DIV == 1:
- out SHALL equal clk combinationally while rst_n is high, and 0 while rst_n is low.
- tick SHALL equal rst_n (constant high while out of reset).
REQ-015 The period SHALL be invariant; no drift or fractional correction.
- Non-integer ratios yield an output frequency of CLK_FREQ/DIV.
REQ-016 There SHALL be no combinational path from rst_n to out except in DIV == 1 mode.

Reset
REQ-017 While rst_n is low, for DIV >= 2: cnt = DIV-1, out = 0, tick = 0, applied immediately without waiting for a clk edge.
REQ-018 On the first clk rising edge after rst_n deasserts:
- cnt becomes 0, out becomes 1, tick becomes 1.
REQ-019 Assertion of rst_n mid-period SHALL abort the current period.
- On release, the output restarts per REQ-018 with no runt or extended pulse beyond that restart.

Verification
REQ-020 CLK_FREQ=100, SAMPLE_RATE=25 (DIV=4):
- After reset release, out per cycle = 1,1,0,0 repeating.
- tick = 1,0,0,0 repeating.
REQ-021 CLK_FREQ=100, SAMPLE_RATE=20 (DIV=5):
- out = 1,1,1,0,0 repeating; tick high once every 5 cycles.
REQ-022 CLK_FREQ=100, SAMPLE_RATE=30 (DIV=3, non-integer ratio):
- out = 1,1,0 repeating; period 3 cycles.
REQ-023 CLK_FREQ=SAMPLE_RATE=48000 (DIV=1):
- out mirrors clk while rst_n=1; out=0 while rst_n=0.
- Also CLK_FREQ=10, SAMPLE_RATE=20: clamps to DIV=1 with the same behaviour.
REQ-024 DIV=4, rst_n pulsed low for 1 ns while out=1 in cycle 2 of a period:
- out and tick drop to 0 at once.
- The first clk edge after release gives out=1, tick=1; the 1,1,0,0 pattern resumes.
REQ-025 Default parameters (DIV=1041):
- Over 10 output periods, measured period is exactly 1041 clk cycles.
- High phase is 521 cycles, low phase 520 cycles.
